// File: rtl/muldiv_pkg.sv
// Package: muldiv_pkg
// Shared types and operation decode helpers for the iterative RV32M
// multiply/divide unit.
//   md_state_t : sequencer states (IDLE, CALC, FIN, DONE)
//   md_op_t    : funct3 encoding of the eight RV32M operations
//   is_div / is_rem / is_high / is_signed_a / is_signed_b : op decode helpers
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } md_op_t;

    // DIV, DIVU, REM, REMU
    function automatic logic is_div(md_op_t op);
        return op[2];
    endfunction

    // REM, REMU
    function automatic logic is_rem(md_op_t op);
        return op[2] & op[1];
    endfunction

    // MULH, MULHSU, MULHU return the upper product half
    function automatic logic is_high(md_op_t op);
        return ~op[2] & (op[1] | op[0]);
    endfunction

    // MUL is treated as signed: the low product half is identical either way.
    function automatic logic is_signed_a(md_op_t op);
        return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) ||
               (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic is_signed_b(md_op_t op);
        return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Module: muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. Operates on operand
// magnitudes: radix-2 shift-add for MUL*, restoring shift-subtract for DIV*/REM*,
// both sharing one 2*DATA_WIDTH shift register, with a final sign-correction
// step. Divide-by-zero and signed overflow bypass the iteration entirely.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   operation request, sampled only in IDLE
//   flush   in   abort current operation; dominates start
//   funct3  in   RV32M op select
//   SrcA    in   rs1 value
//   SrcB    in   rs2 value
//   busy    out  high while an accepted op is in CALC or FIN
//   done    out  one-cycle pulse, Result valid in that cycle
//   Result  out  registered result, holds between operations
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int unsigned W = DATA_WIDTH;

    md_state_t            state_q;
    md_op_t               op_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    // MUL*: {product_hi, product_lo/multiplier}; DIV*: {remainder, quotient/dividend}
    logic [2*W-1:0]       acc_q;
    logic [W-1:0]         opb_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic                 special_q;
    logic                 busy_q;
    logic                 done_q;
    logic [W-1:0]         result_q;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    md_op_t       op_in;
    logic         neg_a;
    logic         neg_b;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         b_zero;
    logic         ovf;
    logic         special_in;
    logic [W-1:0] special_val;

    assign op_in = md_op_t'(funct3);

    always_comb begin
        neg_a      = is_signed_a(op_in) & SrcA[W-1];
        neg_b      = is_signed_b(op_in) & SrcB[W-1];
        mag_a      = neg_a ? (~SrcA + 1'b1) : SrcA;
        mag_b      = neg_b ? (~SrcB + 1'b1) : SrcB;
        b_zero     = (SrcB == '0);
        // Only signed division can overflow: most-negative / -1
        ovf        = is_signed_a(op_in) && is_div(op_in) &&
                     (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});
        special_in = is_div(op_in) && (b_zero || ovf);
        if (b_zero) begin
            special_val = is_rem(op_in) ? SrcA : {W{1'b1}};
        end else begin
            special_val = is_rem(op_in) ? '0 : SrcA;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of each datapath
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_take;
    logic [2*W-1:0] div_next;

    always_comb begin
        // Add multiplicand when the current multiplier LSB is set, then shift
        // the whole product right; the carry enters at the top.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Shift next dividend bit into the partial remainder, trial-subtract.
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_take  = ~div_diff[W];
        div_next  = {(div_take ? div_diff[W-1:0] : div_shift[W-1:0]),
                     acc_q[W-2:0], div_take};
    end

    // ------------------------------------------------------------------
    // Final sign correction and result select
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fin_val;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
        fin_val  = '0;
        if (special_q) begin
            // Special-case result was preloaded into the low half at accept
            fin_val = acc_q[W-1:0];
        end else if (is_rem(op_q)) begin
            fin_val = rem_fix;
        end else if (is_div(op_q)) begin
            fin_val = quo_fix;
        end else if (is_high(op_q)) begin
            fin_val = prod_fix[2*W-1:W];
        end else begin
            fin_val = prod_fix[W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OpMul;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (flush) begin
            // Abort from any state; Result keeps its previous value
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q      <= op_in;
                        opb_q     <= mag_b;
                        cnt_q     <= '0;
                        neg_res_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        special_q <= special_in;
                        busy_q    <= 1'b1;
                        if (special_in) begin
                            acc_q   <= {{W{1'b0}}, special_val};
                            state_q <= FIN;
                        end else begin
                            acc_q   <= {{W{1'b0}}, mag_a};
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= is_div(op_q) ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(W - 1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    result_q <= fin_val;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    // start is ignored here
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_unit #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .flush (flush),
        .funct3(funct3),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .busy  (busy),
        .done  (done),
        .Result(Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Architectural RV32M reference computed with wide arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        int          ia;
        int          ib;
        longint      la;
        longint      lb;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        ia  = a;
        ib  = b;
        la  = ia;
        lb  = ib;
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = la * lb; return p[63:32]; end
            3'd2: begin p = la * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        logic sdiv;
        sdiv = (f == 3'd4) || (f == 3'd6);
        if (f[2] && (b == 0 || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    // Called at a negedge with the DUT idle. Start is asserted in cycle 0;
    // cycles are numbered from the accept edge. Returns at the negedge of
    // the cycle after done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit mutate, input bit start_in_done,
                          output logic [31:0] res, output int lat, output int bcyc,
                          output logic extra_done, output logic busy_after);
        funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcyc  = 0;
        res   = 32'hx;
        for (int k = 1; k <= 60; k++) begin
            if (busy) bcyc++;
            if (done) begin
                lat = k;
                res = Result;
                break;
            end
            if (mutate) begin
                SrcA   = $urandom;
                SrcB   = $urandom;
                funct3 = 3'($urandom_range(0, 7));
                start  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = start_in_done;
        @(negedge clk);
        start      = 1'b0;
        extra_done = done;
        busy_after = busy;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] prev;
        int          lat;
        int          bcyc;
        int          ndone;
        logic        xd;
        logic        ba;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34};
        vecs[3]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 34};
        vecs[6]  = '{3'd5, 32'd20,         32'd3,         32'd6,         34};
        vecs[7]  = '{3'd7, 32'd20,         32'd3,         32'd2,         34};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2};
        vecs[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         34};
        vecs[13] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[14] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[15] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[16] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};
        vecs[17] = '{3'd7, 32'd7,          32'd0,         32'd7,         2};

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", Result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed table, issued back to back; odd entries scramble inputs
        // and pulse start while busy, entry 0 also asserts start during done.
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, bit'(i % 2), (i == 0),
                   res, lat, bcyc, xd, ba);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'(vecs[i].lat - 1));
            check($sformatf("vec%0d_extra_done", i), 32'(xd), 32'd0);
            check($sformatf("vec%0d_busy_after", i), 32'(ba), 32'd0);
        end

        // flush during CALC iteration 10
        funct3 = 3'd0;
        SrcA   = 32'd123;
        SrcB   = 32'd456;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        prev  = Result;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(ndone), 32'd0);
        check("flush_result_hold", Result, prev);
        run_op(3'd0, 32'd123, 32'd456, 1'b0, 1'b0, res, lat, bcyc, xd, ba);
        check("post_flush_result", res, 32'd56088);
        check("post_flush_latency", 32'(lat), 32'd34);

        // flush together with start in IDLE: start is refused
        funct3 = 3'd5;
        SrcA   = 32'd100;
        SrcB   = 32'd7;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush_start_no_done", 32'(ndone), 32'd0);

        // asynchronous reset mid-CALC
        funct3 = 3'd5;
        SrcA   = 32'd1000;
        SrcB   = 32'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("reset_no_done", 32'(ndone), 32'd0);

        // randomized operations against the reference model
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            a   = (sel == 0) ? 32'h8000_0000 : $urandom;
            case (sel)
                1:       b = 32'h0;
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(f, a, b, bit'(n % 3 == 0), 1'b0, res, lat, bcyc, xd, ba);
            check($sformatf("rand%0d_f%0d_%h_%h_result", n, f, a, b), res, ref_model(f, a, b));
            check($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_latency(f, a, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
